// File: rtl/gen_log_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ log requesters, the arbiter and the log sink.
// master: requesters/sink side (drives req, req_data, out_ready); slave: arbiter side.
interface gen_log_rr_arbiter_if #(
    parameter int NUM_REQ = 10,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [IDX_W-1:0]          out_src;
    logic                      out_ready;
    logic                      busy;
    logic [CNT_W-1:0]          msg_cnt;

    modport master (
        output req, req_data, out_ready,
        input  gnt, out_valid, out_data, out_src, busy, msg_cnt
    );

    modport slave (
        input  req, req_data, out_ready,
        output gnt, out_valid, out_data, out_src, busy, msg_cnt
    );
endinterface

// File: rtl/gen_log_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ log requesters into one registered valid/ready channel.
// Ports: clk, rst_n (async active-low), bus (slave modport: req/req_data/gnt, out_*, busy, msg_cnt).
module gen_log_rr_arbiter #(
    parameter int NUM_REQ = 10,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gen_log_rr_arbiter_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0]  words [NUM_REQ];
    logic [NUM_REQ-1:0] gnt_w;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [DATA_W-1:0]  win_word;
    logic               slot_free;
    logic               take;
    logic               hs;

    // Per-requester data slice and grant decode.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign words[i] = bus.req_data[i*DATA_W +: DATA_W];
        assign gnt_w[i] = take && (win_idx == IDX_W'(i));
    end

    // Winner: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[k] && (IDX_W'(k) >= rr_ptr_q)) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        win_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_word = words[k];
            end
        end
    end

    // The output slot frees in the same cycle the sink takes the current word.
    assign slot_free = (state_q == ST_IDLE) || bus.out_ready;
    assign take      = slot_free && win_any;
    assign hs        = (state_q == ST_SEND) && bus.out_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (take) begin
            state_d  = ST_SEND;
            data_d   = win_word;
            src_d    = win_idx;
            rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end else if (hs) begin
            state_d = ST_IDLE;
        end
        if (hs && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_w;
    assign bus.out_valid = (state_q == ST_SEND);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.busy      = (state_q == ST_SEND) || (|bus.req);
    assign bus.msg_cnt   = cnt_q;
endmodule

// File: tb/tb_gen_log_rr_arbiter.sv
// Testbench for gen_log_rr_arbiter: reference round-robin model plus a scoreboard queue
// of captured words checked in order at each output handshake.
module tb_gen_log_rr_arbiter;
    localparam int N  = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gen_log_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(16)) bus ();
    gen_log_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(4))  bus4 ();

    gen_log_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    gen_log_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    int errors = 0;
    int checks = 0;
    int seq = 0;

    int          m_ptr;
    bit          m_valid;
    int          m_cnt;
    int          waitc [N];
    logic [35:0] sbq [$];

    logic [N-1:0]  last_gnt;
    logic          last_valid;
    logic [DW-1:0] last_data;
    logic [15:0]   last_cnt;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        sbq.delete();
        for (int i = 0; i < N; i++) waitc[i] = 0;
    endtask

    task automatic set_word(int i);
        seq++;
        bus.req_data[i*DW +: DW] = {4'hB, 4'(i), 24'(seq)};
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int ew;
        int idx;
        logic [35:0] e;
        #1;
        ew = -1;
        if (!m_valid || bus.out_ready) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (ew < 0 && bus.req[idx]) ew = idx;
            end
        end
        check("gnt", 64'(bus.gnt), (ew >= 0) ? (64'(1) << ew) : 64'(0));
        check("valid", 64'(bus.out_valid), 64'(m_valid));
        check("busy", 64'(bus.busy), 64'(m_valid || (|bus.req)));
        check("cnt", 64'(bus.msg_cnt), 64'(m_cnt));
        if (m_valid && bus.out_ready) begin
            check("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("sb_data", 64'(bus.out_data), 64'(e[31:0]));
                check("sb_src", 64'(bus.out_src), 64'(e[35:32]));
            end
            if (m_cnt != 65535) m_cnt++;
        end
        for (int i = 0; i < N; i++) begin
            if (!bus.req[i]) begin
                waitc[i] = 0;
            end else if (ew >= 0) begin
                waitc[i]++;
                if (i == ew) begin
                    check("starve", 64'(waitc[i] <= N), 64'(1));
                    waitc[i] = 0;
                end
            end
        end
        if (ew >= 0) begin
            sbq.push_back({4'(ew), bus.req_data[ew*DW +: DW]});
            m_ptr   = (ew + 1) % N;
            m_valid = 1'b1;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        last_gnt   = bus.gnt;
        last_valid = bus.out_valid;
        last_data  = bus.out_data;
        last_cnt   = bus.msg_cnt;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req       = '0;
        bus.out_ready = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        logic [15:0] c0;
        rst_n          = 1'b0;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.out_ready  = 1'b0;
        bus4.req       = '0;
        bus4.req_data  = '0;
        bus4.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_src", 64'(bus.out_src), 64'(0));
        check("rst_cnt", 64'(bus.msg_cnt), 64'(0));
        check("rst_gnt", 64'(bus.gnt), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Saturating counter on the narrow instance.
        bus4.req[0]    = 1'b1;
        bus4.req_data  = {(N*DW/32){32'h0000_1234}};
        bus4.out_ready = 1'b1;
        repeat (11) @(negedge clk);
        check("t6_cnt10", 64'(bus4.msg_cnt), 64'(10));
        repeat (14) @(negedge clk);
        check("t6_sat", 64'(bus4.msg_cnt), 64'(15));
        bus4.req = '0;

        // All requesters held high: strict rotation 0..9 then 0.
        for (int i = 0; i < N; i++) set_word(i);
        bus.req       = '1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            step();
            check("t1_order", 64'(last_gnt), 64'(1) << (k % N));
            for (int i = 0; i < N; i++) if (last_gnt[i]) set_word(i);
        end
        bus.req = '0;
        step();
        check("t1_cnt", 64'(last_cnt), 64'(10));
        drain();

        // Single requester with a stalled sink.
        bus.req_data[3*DW +: DW] = 32'hDEAD_0003;
        bus.req       = N'(1) << 3;
        bus.out_ready = 1'b0;
        step();
        check("t2_gnt", 64'(last_gnt), 64'(1) << 3);
        bus.req = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_valid", 64'(last_valid), 64'(1));
            check("t2_data", 64'(last_data), 64'(32'hDEAD_0003));
            check("t2_nognt", 64'(last_gnt), 64'(0));
        end
        c0 = last_cnt;
        bus.out_ready = 1'b1;
        step();
        step();
        check("t2_cnt", 64'(last_cnt), 64'(c0) + 64'(1));

        // Pointer wrap from 9 back to 2, then 3.
        set_word(8);
        bus.req = N'(1) << 8;
        step();
        set_word(9);
        set_word(2);
        bus.req = (N'(1) << 9) | (N'(1) << 2);
        step();
        check("t3_g9", 64'(last_gnt), 64'(1) << 9);
        bus.req = N'(1) << 2;
        step();
        check("t3_g2", 64'(last_gnt), 64'(1) << 2);
        set_word(1);
        set_word(3);
        bus.req = (N'(1) << 1) | (N'(1) << 3);
        step();
        check("t3_g3", 64'(last_gnt), 64'(1) << 3);
        drain();

        // Asynchronous reset while a word is pending.
        set_word(5);
        bus.req       = N'(1) << 5;
        bus.out_ready = 1'b0;
        step();
        bus.req = '0;
        step();
        check("t4_src", 64'(bus.out_src), 64'(5));
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_valid", 64'(bus.out_valid), 64'(0));
        check("t4_srcrst", 64'(bus.out_src), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_word(0);
        set_word(5);
        bus.req       = (N'(1) << 5) | N'(1);
        bus.out_ready = 1'b1;
        step();
        check("t4_g0", 64'(last_gnt), 64'(1));
        bus.req[0] = 1'b0;
        step();
        check("t4_g5", 64'(last_gnt), 64'(1) << 5);
        drain();

        // Random requests and sink backpressure.
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) begin
                    if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
                    else set_word(i);
                end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
                    set_word(i);
                    bus.req[i] = 1'b1;
                end
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
        end
        drain();
        check("sb_empty", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
